pong_ball_ctrl: RTL and testbench
=================================

// Module: pong_ball_ctrl
// PURPOSE
// Ball engine for Pong; sits downstream of both paddle controllers. Consumes their paddle
// rows, moves the ball on a PIXEL_SIZE grid, bounces off walls/paddles, and emits the
// registered ball draw bit plus a one-cycle o_Out miss pulse.
// o_Out feeds the paddles' i_Out input and the scoreboard.
// PARAMETERS
// HMAX 800 | VMAX 525: VGA counter ranges.
// WIDTH 40 | HEIGHT 30: grid columns/rows.
// PIXEL_SIZE 16: pixels per grid cell.
// P1_H_POS 5: left paddle column; front face is column P1_H_POS-1.
// P2_H_POS 35: right paddle column; front face is column P2_H_POS.
// Y_MIN 1 | Y_MAX 28: top/bottom wall rows.
// BALL_SPEED 1250000: clocks per ball step.
// SPEEDUP_STEP 62500 | SPEED_MIN 312500: used only with BALL_SPEEDUP_EN.
// PORTS
// i_Clk        in   1                 system/pixel clock
// i_Reset      in   1                 synchronous, active-high reset
// i_H_count    in   $clog2(HMAX)      VGA column counter
// i_V_count    in   $clog2(VMAX)      VGA row counter
// i_Ready      in   1                 RESET->START
// i_Start      in   1                 START->PLAY (serve)
// i_P1_V_pos   in   $clog2(HEIGHT)    left paddle centre row
// i_P2_V_pos   in   $clog2(HEIGHT)    right paddle centre row
// o_Draw_Ball  out  1                 ball pixel, registered
// o_Out        out  1                 1-cycle pulse on miss
// o_P1_Point   out  1                 1-cycle pulse: left player scored (with o_Out)
// o_P2_Point   out  1                 1-cycle pulse: right player scored (with o_Out)
// o_Ball_X     out  $clog2(WIDTH)     ball column
// o_Ball_Y     out  $clog2(HEIGHT)    ball row
// BEHAVIOUR
// Reset (i_Reset=1): state RESET, X=WIDTH/2 (20), Y=HEIGHT/2 (15), dx=+1, dy=+1, timer=0,
//   all 1-bit outputs 0. Reset has priority over every other event, incl. mid-step/mid-score.
// FSM: RESET -i_Ready-> START -i_Start-> PLAY -miss-> SCORE -(1 cycle)-> START.
// RESET: ball hidden, position held at centre.
// START: ball drawn at centre, timer held at 0.
// PLAY: timer counts 0..period-1; on terminal count, timer clears and one step executes.
// Step, evaluated on current X,Y,dx,dy:
//   Vertical: if (Y==Y_MIN && dy<0) or (Y==Y_MAX && dy>0), flip dy and move Y one row the
//     new way; else Y+=dy.
//   Left hit: dx<0 && X==P1_H_POS && P1_V-3<=Y<=P1_V+2 -> dx=+1, X=X+1.
//   Right hit: dx>0 && X==P2_H_POS-1 && P2_V-3<=Y<=P2_V+2 -> dx=-1, X=X-1.
//   Otherwise X+=dx. Wall and paddle flips in the same step are both applied (corner).
//   Paddle range compares use signed/extended arithmetic; no wrap when V_pos<3.
// Miss: after a step, X==0 -> SCORE with P2 scoring; X==WIDTH-1 -> SCORE with P1 scoring.
// SCORE (1 cycle): o_Out=1 plus the matching Px_Point=1.
//   Ball recentres; dy=+1; dx points toward the player who conceded.
//   Timer and period are reset. Next cycle: START.
// Draw: o_Draw_Ball <= (state!=RESET) && i_H_count/PIXEL_SIZE==X && i_V_count/PIXEL_SIZE==Y
//   && i_H_count<WIDTH*PIXEL_SIZE && i_V_count<HEIGHT*PIXEL_SIZE. Latency 1 clock.
// o_Ball_X/Y: direct register outputs. i_Ready/i_Start are ignored outside their own states.
// CONFIGURATION
// BALL_SPEEDUP_EN defined:
//   - Step period starts at BALL_SPEED.
//   - Each paddle hit reduces it by SPEEDUP_STEP, saturating at SPEED_MIN.
//   - Period restored to BALL_SPEED on SCORE and reset.
// BALL_SPEEDUP_EN undefined: period is constant BALL_SPEED; SPEEDUP_* are unused.
// TESTING (BALL_SPEED=4 in sim)
// 1. Reset, i_Ready, i_Start, 4 clocks -> X=21, Y=16, o_Out=0.
// 2. Y=28, dy=+1, step -> Y=27, dy=-1; Y=1, dy=-1, step -> Y=2, dy=+1.
// 3. X=34, dx=+1, Y=15, i_P2_V_pos=16, step -> X=33, dx=-1.
//    Same with i_P2_V_pos=20 -> X=35, no bounce.
// 4. Left miss: ball reaches X=0 -> o_Out and o_P2_Point high exactly 1 cycle.
//    Then START, X=20, Y=15, dx=-1; ball stays still until i_Start.
// 5. i_Reset asserted mid-PLAY on step cycle -> next cycle RESET, centre, o_Draw_Ball=0, no o_Out.
// 6. START, H=320..335, V=240..255 -> o_Draw_Ball=1 one clock later; H=336 -> 0.
//    With BALL_SPEEDUP_EN: 2 hits -> period 1250000-125000.

Source files
------------

// File: rtl/pong_ball_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_ball_ctrl: Pong ball engine - grid motion, wall/paddle bounce, miss.   |
// | Optional macro BALL_SPEEDUP_EN: each paddle hit shortens the step period.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pong_ball_ctrl #(
  parameter int HMAX         = 800,
  parameter int VMAX         = 525,
  parameter int WIDTH        = 40,
  parameter int HEIGHT       = 30,
  parameter int PIXEL_SIZE   = 16,
  parameter int P1_H_POS     = 5,
  parameter int P2_H_POS     = 35,
  parameter int Y_MIN        = 1,
  parameter int Y_MAX        = 28,
  parameter int BALL_SPEED   = 1250000,
  parameter int SPEEDUP_STEP = 62500,
  parameter int SPEED_MIN    = 312500
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [$clog2(HMAX)-1:0]   i_H_count,
  input  logic [$clog2(VMAX)-1:0]   i_V_count,
  input  logic                      i_Ready,
  input  logic                      i_Start,
  input  logic [$clog2(HEIGHT)-1:0] i_P1_V_pos,
  input  logic [$clog2(HEIGHT)-1:0] i_P2_V_pos,
  output logic                      o_Draw_Ball,
  output logic                      o_Out,
  output logic                      o_P1_Point,
  output logic                      o_P2_Point,
  output logic [$clog2(WIDTH)-1:0]  o_Ball_X,
  output logic [$clog2(HEIGHT)-1:0] o_Ball_Y
);

  localparam int HW   = $clog2(HMAX);
  localparam int VW   = $clog2(VMAX);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int CW   = YW + 2;
  localparam int PMAX = (BALL_SPEED > SPEED_MIN) ? BALL_SPEED : SPEED_MIN;
  localparam int TW   = $clog2(PMAX + SPEEDUP_STEP + 1);

  localparam logic [XW-1:0] X_CENTRE = XW'(WIDTH / 2);
  localparam logic [YW-1:0] Y_CENTRE = YW'(HEIGHT / 2);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_START = 2'd1,
    S_PLAY  = 2'd2,
    S_SCORE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            dx_neg_q, dx_neg_d;
  logic            dy_neg_q, dy_neg_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            p1_scored_q, p1_scored_d;
  logic            draw_q;
  logic [TW-1:0]   period;

  logic            w_step;
  logic            w_terminal;
  logic            w_wall;
  logic            w_dy_neg_nx;
  logic [YW-1:0]   w_y_nx;
  logic [CW-1:0]   w_y_ext, w_p1_ext, w_p2_ext;
  logic            w_hit_l, w_hit_r;
  logic            w_dx_neg_nx;
  logic [XW-1:0]   w_x_nx;
  logic [HW-1:0]   w_h_cell;
  logic [VW-1:0]   w_v_cell;
  logic            w_draw;
  logic            w_scoring;

  assign w_terminal = (timer_q == period - TW'(1));

  // Step datapath, always evaluated on the current position/direction.
  assign w_wall      = ((y_q == YW'(Y_MIN)) && dy_neg_q) || ((y_q == YW'(Y_MAX)) && !dy_neg_q);
  assign w_dy_neg_nx = dy_neg_q ^ w_wall;
  assign w_y_nx      = w_dy_neg_nx ? (y_q - YW'(1)) : (y_q + YW'(1));

  // Widened so that paddle rows near zero never wrap the hit window.
  assign w_y_ext  = CW'(y_q);
  assign w_p1_ext = CW'(i_P1_V_pos);
  assign w_p2_ext = CW'(i_P2_V_pos);
  assign w_hit_l  = dx_neg_q && (x_q == XW'(P1_H_POS)) &&
                    (w_y_ext + CW'(3) >= w_p1_ext) && (w_y_ext <= w_p1_ext + CW'(2));
  assign w_hit_r  = !dx_neg_q && (x_q == XW'(P2_H_POS - 1)) &&
                    (w_y_ext + CW'(3) >= w_p2_ext) && (w_y_ext <= w_p2_ext + CW'(2));

  assign w_dx_neg_nx = w_hit_l ? 1'b0 : (w_hit_r ? 1'b1 : dx_neg_q);
  assign w_x_nx      = w_dx_neg_nx ? (x_q - XW'(1)) : (x_q + XW'(1));

  assign w_h_cell = i_H_count / HW'(PIXEL_SIZE);
  assign w_v_cell = i_V_count / VW'(PIXEL_SIZE);
  assign w_draw   = (state_q != S_RESET) &&
                    (w_h_cell == HW'(x_q)) && (w_v_cell == VW'(y_q)) &&
                    (i_H_count < HW'(WIDTH * PIXEL_SIZE)) &&
                    (i_V_count < VW'(HEIGHT * PIXEL_SIZE));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= S_RESET;
      x_q         <= X_CENTRE;
      y_q         <= Y_CENTRE;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      timer_q     <= '0;
      p1_scored_q <= 1'b0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      timer_q     <= timer_d;
      p1_scored_q <= p1_scored_d;
      draw_q      <= w_draw;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    timer_d     = timer_q;
    p1_scored_d = p1_scored_q;
    w_step      = 1'b0;
    case (state_q)
      S_RESET: begin
        if (i_Ready) state_d = S_START;
      end
      S_START: begin
        timer_d = '0;
        if (i_Start) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (w_terminal) begin
          w_step   = 1'b1;
          timer_d  = '0;
          x_d      = w_x_nx;
          y_d      = w_y_nx;
          dx_neg_d = w_dx_neg_nx;
          dy_neg_d = w_dy_neg_nx;
          if (w_x_nx == '0) begin
            state_d     = S_SCORE;
            p1_scored_d = 1'b0;
          end else if (w_x_nx == XW'(WIDTH - 1)) begin
            state_d     = S_SCORE;
            p1_scored_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_SCORE: begin
        // Serve toward whoever conceded the point.
        x_d      = X_CENTRE;
        y_d      = Y_CENTRE;
        dy_neg_d = 1'b0;
        dx_neg_d = !p1_scored_q;
        timer_d  = '0;
        state_d  = S_START;
      end
      default: state_d = S_RESET;
    endcase
  end

`ifdef BALL_SPEEDUP_EN
  logic [TW-1:0] period_q, period_d;

  always_comb begin
    period_d = period_q;
    if (state_q == S_SCORE) begin
      period_d = TW'(BALL_SPEED);
    end else if (w_step && (w_hit_l || w_hit_r)) begin
      if (period_q >= TW'(SPEED_MIN + SPEEDUP_STEP)) period_d = period_q - TW'(SPEEDUP_STEP);
      else                                           period_d = TW'(SPEED_MIN);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) period_q <= TW'(BALL_SPEED);
    else         period_q <= period_d;
  end

  assign period = period_q;
`else
  assign period = TW'(BALL_SPEED);
`endif

  assign w_scoring   = (state_q == S_SCORE);
  assign o_Out       = w_scoring;
  assign o_P1_Point  = w_scoring && p1_scored_q;
  assign o_P2_Point  = w_scoring && !p1_scored_q;
  assign o_Draw_Ball = draw_q;
  assign o_Ball_X    = x_q;
  assign o_Ball_Y    = y_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_ctrl.sv
`default_nettype none
// Bench for pong_ball_ctrl: integer game model, draw vector table, scripted rallies, random play.
module tb_pong_ball_ctrl;

  localparam int BS       = 4;
  localparam int SPD_STEP = 1;
  localparam int SPD_MIN  = 2;

  localparam int M_RESET = 0;
  localparam int M_START = 1;
  localparam int M_PLAY  = 2;
  localparam int M_SCORE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h = '0;
  logic [9:0] v = '0;
  logic       ready = 1'b0;
  logic       start = 1'b0;
  logic [4:0] p1 = 5'd20;
  logic [4:0] p2 = 5'd20;
  logic       o_Draw_Ball, o_Out, o_P1_Point, o_P2_Point;
  logic [5:0] o_Ball_X;
  logic [4:0] o_Ball_Y;

  always #5 clk = ~clk;

  pong_ball_ctrl #(
    .BALL_SPEED  (BS),
    .SPEEDUP_STEP(SPD_STEP),
    .SPEED_MIN   (SPD_MIN)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_H_count  (h),
    .i_V_count  (v),
    .i_Ready    (ready),
    .i_Start    (start),
    .i_P1_V_pos (p1),
    .i_P2_V_pos (p2),
    .o_Draw_Ball(o_Draw_Ball),
    .o_Out      (o_Out),
    .o_P1_Point (o_P1_Point),
    .o_P2_Point (o_P2_Point),
    .o_Ball_X   (o_Ball_X),
    .o_Ball_Y   (o_Ball_Y)
  );

  int total = 0;
  int bad   = 0;

  int m_st = M_RESET, m_x = 20, m_y = 15, m_dx = 1, m_dy = 1;
  int m_t = 0, m_per = BS, m_scorer = 0, m_steps = 0;
  bit m_draw = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One ball move from the game rules, on integer coordinates.
  task automatic model_move();
    int  ox, oy;
    bit  hit;
    ox  = m_x;
    oy  = m_y;
    hit = 1'b0;
    if ((oy == 1 && m_dy < 0) || (oy == 28 && m_dy > 0)) m_dy = -m_dy;
    m_y = oy + m_dy;
    if (m_dx < 0 && ox == 5 && oy >= int'(p1) - 3 && oy <= int'(p1) + 2) begin
      m_dx = 1;
      hit  = 1'b1;
    end else if (m_dx > 0 && ox == 34 && oy >= int'(p2) - 3 && oy <= int'(p2) + 2) begin
      m_dx = -1;
      hit  = 1'b1;
    end
    m_x = ox + m_dx;
`ifdef BALL_SPEEDUP_EN
    if (hit) m_per = (m_per - SPD_STEP < SPD_MIN) ? SPD_MIN : m_per - SPD_STEP;
`endif
    if (hit) m_steps = m_steps + 0;
  endtask

  task automatic model_edge();
    m_draw = (m_st != M_RESET) && (int'(h) / 16 == m_x) && (int'(v) / 16 == m_y) &&
             (int'(h) < 640) && (int'(v) < 480);
    if (rst) begin
      m_st = M_RESET; m_x = 20; m_y = 15; m_dx = 1; m_dy = 1;
      m_t = 0; m_per = BS; m_draw = 1'b0;
      return;
    end
    case (m_st)
      M_RESET: if (ready) m_st = M_START;
      M_START: begin
        m_t = 0;
        if (start) m_st = M_PLAY;
      end
      M_PLAY: begin
        if (m_t == m_per - 1) begin
          m_t = 0;
          m_steps++;
          model_move();
          if (m_x == 0) begin
            m_st = M_SCORE; m_scorer = 2;
          end else if (m_x == 39) begin
            m_st = M_SCORE; m_scorer = 1;
          end
        end else begin
          m_t++;
        end
      end
      default: begin
        m_x = 20; m_y = 15; m_dy = 1;
        m_dx = (m_scorer == 2) ? -1 : 1;
        m_t = 0; m_per = BS; m_st = M_START;
      end
    endcase
  endtask

  task automatic cycle();
    logic [14:0] a, e;
    model_edge();
    @(posedge clk);
    #1;
    a = {o_Draw_Ball, o_Out, o_P1_Point, o_P2_Point, o_Ball_X, o_Ball_Y};
    e = {m_draw, (m_st == M_SCORE), (m_st == M_SCORE && m_scorer == 1),
         (m_st == M_SCORE && m_scorer == 2), 6'(m_x), 5'(m_y)};
    check("cycle_vs_model", int'(a), int'(e));
  endtask

  task automatic do_steps(input int n);
    int target, guard;
    target = m_steps + n;
    guard  = 0;
    while (m_steps < target && guard < 4000) begin
      cycle();
      guard++;
    end
    check("step_budget", m_steps, target);
  endtask

  task automatic reset_to_start();
    rst = 1'b1; ready = 1'b0; start = 1'b0;
    cycle(); cycle();
    rst = 1'b0; ready = 1'b1;
    cycle();
    ready = 1'b0;
  endtask

  task automatic serve();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Long rally: right wall, right paddle, top wall, then left paddle hit or miss.
  task automatic rally(input logic [4:0] left_row);
    p1 = left_row; p2 = 5'd26; h = '0; v = '0;
    reset_to_start();
    check("reset_x", int'(o_Ball_X), 20);
    check("reset_y", int'(o_Ball_Y), 15);
    serve();
    do_steps(1);
    check("first_step_x", int'(o_Ball_X), 21);
    check("first_step_y", int'(o_Ball_Y), 16);
    check("first_step_out", int'(o_Out), 0);
    do_steps(12);
    check("at_bottom_y", int'(o_Ball_Y), 28);
    do_steps(1);
    check("bottom_bounce_y", int'(o_Ball_Y), 27);
    check("bottom_bounce_x", int'(o_Ball_X), 34);
    do_steps(1);
    check("p2_hit_x", int'(o_Ball_X), 33);
    do_steps(26);
    check("top_bounce_y", int'(o_Ball_Y), 2);
    check("top_bounce_x", int'(o_Ball_X), 7);
    do_steps(3);
    check("left_face_x", int'(o_Ball_X), (left_row == 5'd2) ? 6 : 4);
  endtask

  typedef struct {
    int h;
    int v;
    bit exp;
  } draw_vec_t;

  draw_vec_t vecs[9];

  initial begin
    vecs[0] = '{320, 240, 1'b1};
    vecs[1] = '{335, 255, 1'b1};
    vecs[2] = '{336, 240, 1'b0};
    vecs[3] = '{319, 240, 1'b0};
    vecs[4] = '{327, 247, 1'b1};
    vecs[5] = '{320, 256, 1'b0};
    vecs[6] = '{320, 239, 1'b0};
    vecs[7] = '{335, 240, 1'b1};
    vecs[8] = '{0,   0,   1'b0};

    // Draw window with the ball parked at centre in START.
    reset_to_start();
    foreach (vecs[i]) begin
      h = 10'(vecs[i].h);
      v = 10'(vecs[i].v);
      cycle();
      check("draw_vec", int'(o_Draw_Ball), int'(vecs[i].exp));
    end

    // Left paddle at row 2 catches the ball at row 4 (window -1..4, no wrap).
    rally(5'd2);

    // Left paddle far away: ball runs out at column 0.
    rally(5'd20);
    do_steps(4);
    check("miss_out", int'(o_Out), 1);
    check("miss_p2_point", int'(o_P2_Point), 1);
    check("miss_p1_point", int'(o_P1_Point), 0);
    check("miss_x", int'(o_Ball_X), 0);
    cycle();
    check("after_miss_out", int'(o_Out), 0);
    check("recentre_x", int'(o_Ball_X), 20);
    check("recentre_y", int'(o_Ball_Y), 15);
    for (int i = 0; i < 8; i++) cycle();
    check("held_until_start_x", int'(o_Ball_X), 20);
    serve();
    do_steps(1);
    check("serve_left_x", int'(o_Ball_X), 19);
    check("serve_left_y", int'(o_Ball_Y), 16);

    // Right paddle misses: P1 scores, then serve goes right.
    p1 = 5'd20; p2 = 5'd20;
    reset_to_start();
    serve();
    do_steps(15);
    check("p2_no_hit_x", int'(o_Ball_X), 35);
    do_steps(4);
    check("right_miss_p1_point", int'(o_P1_Point), 1);
    check("right_miss_p2_point", int'(o_P2_Point), 0);
    check("right_miss_out", int'(o_Out), 1);
    cycle();
    serve();
    do_steps(1);
    check("serve_right_x", int'(o_Ball_X), 21);

    // Reset on the very cycle a step would fire, with the beam on the ball.
    reset_to_start();
    h = 10'd323; v = 10'd243;
    serve();
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    check("mid_step_reset_x", int'(o_Ball_X), 20);
    check("mid_step_reset_y", int'(o_Ball_Y), 15);
    check("mid_step_reset_draw", int'(o_Draw_Ball), 0);
    check("mid_step_reset_out", int'(o_Out), 0);
    rst = 1'b0;

    // Random play against the model.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 399) == 0);
      ready = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        int r;
        if ($urandom_range(0, 1) == 1) begin
          r = m_y + int'($urandom_range(0, 6)) - 3;
          if (r < 0) r = 0;
          if (r > 29) r = 29;
        end else begin
          r = int'($urandom_range(0, 29));
        end
        if ($urandom_range(0, 1) == 1) p1 = 5'(r);
        else                           p2 = 5'(r);
      end
      if ($urandom_range(0, 1) == 1) begin
        int hh, vv;
        hh = m_x * 16 + int'($urandom_range(0, 31)) - 8;
        vv = m_y * 16 + int'($urandom_range(0, 31)) - 8;
        h  = 10'((hh < 0) ? 0 : hh);
        v  = 10'((vv < 0) ? 0 : vv);
      end else begin
        h = 10'($urandom_range(0, 799));
        v = 10'($urandom_range(0, 524));
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
